addroundkey: RTL and testbench
==============================

Name: addroundkey

Overview:
- Sequential AddRoundKey stage of the AES-128 encryption datapath.
- Sits directly downstream of mixcol. It also takes shiftrows output for the final round and the raw plaintext for the initial round.
- XORs the selected 128-bit state with the round key from the key schedule and registers the result.
- Tracks the round count, requests keys, and flags block completion after the last round.

Parameters:
- NUM_ROUNDS, 10: number of cipher rounds after the initial key addition (AES-128).
- RCNT_W, 4: width of the round counter; must hold 0..NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begin a new block at round 0 using plain_text.
- plain_text  input  128  input block; sampled when start=1.
- addkey_enable  input  1  one-cycle pulse; upstream data for the current round is valid.
- mix_data  input  128  mixcol output; the source for rounds 1..NUM_ROUNDS-1.
- shift_data  input  128  shiftrows output; the source for round NUM_ROUNDS.
- round_key  input  128  round key for round_num.
- key_valid  input  1  round_key is valid this cycle.
- key_req  output  1  high while the block needs round_key for round_num.
- state_out  output  128  registered result of the last key addition.
- round_num  output  RCNT_W  round currently being processed or awaited.
- addkey_finished  output  1  one-cycle pulse; state_out updated.
- cipher_done  output  1  one-cycle pulse; state_out holds the final ciphertext.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (n_rst=0, asynchronous): state to IDLE. The following outputs are all 0: state_out, round_num, key_req, addkey_finished, cipher_done, busy. The capture register is also cleared to 0.
- States: IDLE, WAIT_DATA, WAIT_KEY, APPLY.
- IDLE:
  - start=1: capture plain_text, round_num=0, go to WAIT_KEY.
  - addkey_enable is ignored.
- WAIT_DATA:
  - Waits for addkey_enable.
  - Source mux on addkey_enable: mix_data if round_num<NUM_ROUNDS; shift_data if round_num==NUM_ROUNDS.
  - The selected source is captured and the state goes to WAIT_KEY.
- WAIT_KEY:
  - key_req=1.
  - On key_valid=1: state_out <= capture ^ round_key (bitwise, 128 bits, byte order unchanged), then go to APPLY.
  - round_key is sampled only in the key_valid cycle.
- Fast path: data capture and key_valid in the same cycle (including key_valid already high on entry) do not wait.
  - Timing: input event at cycle N, state_out valid at N+1.
  - Worst case: data at N, key at M≥N, state_out at M+1.
- APPLY (one cycle):
  - addkey_finished=1.
  - If round_num==NUM_ROUNDS: cipher_done=1 in the same cycle, round_num<=0, go to IDLE.
  - Otherwise: round_num<=round_num+1, go to WAIT_DATA.
- state_out holds its value until the next key addition; it is not cleared on cipher_done.
- busy=1 in WAIT_DATA, WAIT_KEY and APPLY.
- key_req is registered and low in all states other than WAIT_KEY.
- start while busy:
  - Aborts the current block, recaptures plain_text, round_num=0, goes to WAIT_KEY.
  - start has priority over addkey_enable and key_valid in the same cycle.
  - No addkey_finished or cipher_done is issued for the aborted block.
- addkey_enable outside WAIT_DATA (or IDLE without start): ignored, with no capture.
- key_valid outside WAIT_KEY: ignored.
- The round counter never exceeds NUM_ROUNDS and wraps to 0 only via APPLY of the final round or via start.
- Reset mid-block: immediate return to IDLE with all outputs 0; a new start is required.

Test Plan:
- FIPS-197 vector, round 0:
  - Stimulus: start with plain_text=3243f6a8885a308d313198a2e0370734; key_valid held high with round_key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: state_out=193de3bea0f4e22b9ac68d2ae9f84808 one cycle after capture; addkey_finished pulse; round_num becomes 1.
- Key stall:
  - Stimulus: addkey_enable with mix_data=0x00..00; key_valid delayed 5 cycles; round_key=0xA5..A5.
  - Required: key_req high for 5 cycles; state_out=0xA5..A5 the cycle after key_valid; no early addkey_finished.
- Full block:
  - Stimulus: start, then 10 addkey_enable pulses, each with key_valid=1. Rounds 1..9 drive mix_data=0x11..11; round 10 drives shift_data=0xFF..FF, mix_data=0x00..00, round_key=0x0F..0F.
  - Required: state_out=0xF0..F0 (shift_data selected); exactly 11 addkey_finished pulses; cipher_done coincident with the last; then busy=0 and round_num=0.
- Abort:
  - Stimulus: start at round 4, with new plain_text=0x01..01 and key 0x01..01.
  - Required: round_num=0, state_out=0x00..00, no cipher_done for the first block.
- Spurious inputs:
  - Stimulus: addkey_enable in IDLE and during WAIT_KEY; key_valid in WAIT_DATA.
  - Required: no state_out change, no addkey_finished, round_num unchanged.
- Async reset:
  - Stimulus: assert n_rst=0 mid-WAIT_KEY between clock edges.
  - Required: all outputs 0 immediately; after deassertion the block stays IDLE until start.

Source files
------------

// File: rtl/addroundkey_if.sv
// Bus between the AES round pipeline / key schedule and the AddRoundKey stage.
// The master modport is the environment side; the slave modport is the stage itself.
interface addroundkey_if #(
    parameter int RCNT_W = 4
);
    logic              start;
    logic [127:0]      plain_text;
    logic              addkey_enable;
    logic [127:0]      mix_data;
    logic [127:0]      shift_data;
    logic [127:0]      round_key;
    logic              key_valid;
    logic              key_req;
    logic [127:0]      state_out;
    logic [RCNT_W-1:0] round_num;
    logic              addkey_finished;
    logic              cipher_done;
    logic              busy;

    modport master (
        output start, plain_text, addkey_enable, mix_data, shift_data, round_key, key_valid,
        input  key_req, state_out, round_num, addkey_finished, cipher_done, busy
    );

    modport slave (
        input  start, plain_text, addkey_enable, mix_data, shift_data, round_key, key_valid,
        output key_req, state_out, round_num, addkey_finished, cipher_done, busy
    );
endinterface

// File: rtl/addroundkey.sv
// AES-128 AddRoundKey stage: XORs the selected 128-bit state with the round key and registers it.
// Latency: one cycle from the later of data/key to state_out; the stage stalls in WAIT_KEY until key_valid.
module addroundkey #(
    parameter int NUM_ROUNDS = 10,
    parameter int RCNT_W     = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    addroundkey_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_KEY, APPLY} state_t;

    localparam logic [RCNT_W-1:0] LAST_ROUND = RCNT_W'(NUM_ROUNDS);

    state_t            state, state_nxt;
    logic [127:0]      cap, cap_nxt;
    logic [127:0]      sout, sout_nxt;
    logic [RCNT_W-1:0] rnd, rnd_nxt;
    logic              key_req_r, key_req_nxt;
    logic [127:0]      src;

    // The final round bypasses mixcol, so its state comes from shiftrows.
    assign src = (rnd == LAST_ROUND) ? bus.shift_data : bus.mix_data;

    always_comb begin
        state_nxt = state;
        cap_nxt   = cap;
        sout_nxt  = sout;
        rnd_nxt   = rnd;
        if (bus.start) begin
            // A new block always wins, aborting whatever was in flight.
            cap_nxt = bus.plain_text;
            rnd_nxt = '0;
            if (bus.key_valid) begin
                sout_nxt  = bus.plain_text ^ bus.round_key;
                state_nxt = APPLY;
            end else begin
                state_nxt = WAIT_KEY;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                WAIT_DATA: begin
                    if (bus.addkey_enable) begin
                        cap_nxt = src;
                        if (bus.key_valid) begin
                            sout_nxt  = src ^ bus.round_key;
                            state_nxt = APPLY;
                        end else begin
                            state_nxt = WAIT_KEY;
                        end
                    end
                end
                WAIT_KEY: begin
                    if (bus.key_valid) begin
                        sout_nxt  = cap ^ bus.round_key;
                        state_nxt = APPLY;
                    end
                end
                APPLY: begin
                    if (rnd == LAST_ROUND) begin
                        rnd_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        rnd_nxt   = rnd + RCNT_W'(1);
                        state_nxt = WAIT_DATA;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        key_req_nxt = (state_nxt == WAIT_KEY);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cap       <= '0;
            sout      <= '0;
            rnd       <= '0;
            key_req_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            cap       <= cap_nxt;
            sout      <= sout_nxt;
            rnd       <= rnd_nxt;
            key_req_r <= key_req_nxt;
        end
    end

    // A start landing on the APPLY cycle aborts that block, so its completion pulses are withheld.
    assign bus.addkey_finished = (state == APPLY) && !bus.start;
    assign bus.cipher_done     = (state == APPLY) && (rnd == LAST_ROUND) && !bus.start;
    assign bus.busy            = (state != IDLE);
    assign bus.key_req         = key_req_r;
    assign bus.state_out       = sout;
    assign bus.round_num       = rnd;
endmodule

// File: tb/tb_addroundkey.sv
// Bench for addroundkey: randomized rounds against a scoreboard, plus directed boundary cases.
module tb_addroundkey;
    localparam int NR = 10;

    typedef struct {
        logic [127:0] so;
        logic [3:0]   rn;
        logic         done;
    } exp_t;

    logic clk;
    logic n_rst;
    addroundkey_if #(.RCNT_W(4)) bus ();

    addroundkey #(.NUM_ROUNDS(NR), .RCNT_W(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int fin_cnt   = 0;
    int done_cnt  = 0;
    int exp_done  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every completion pulse is matched against the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.addkey_finished === 1'b1) begin
                fin_cnt++;
                if (bus.cipher_done === 1'b1) done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_finish actual=1 required=0 state_out=%h round=%0d",
                             bus.state_out, bus.round_num);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_state_out", bus.state_out, e.so);
                    chk("sb_round_num", 128'(bus.round_num), 128'(e.rn));
                    chk("sb_cipher_done", 128'(bus.cipher_done), 128'(e.done));
                end
            end else if (bus.cipher_done === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL lone_cipher_done actual=1 required=0");
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic key_after(input logic [127:0] key, input int dly);
        if (dly > 0) begin
            repeat (dly - 1) tick();
            bus.round_key = key;
            bus.key_valid = 1'b1;
            tick();
            bus.key_valid = 1'b0;
        end
    endtask

    // Round 0 of the cipher: the plaintext itself is whitened with the key.
    task automatic issue_start(input logic [127:0] pt, input logic [127:0] key, input int dly);
        exp_q.push_back('{pt ^ key, 4'd0, 1'b0});
        tick();
        bus.start      = 1'b1;
        bus.plain_text = pt;
        bus.round_key  = key;
        bus.key_valid  = (dly == 0);
        tick();
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        key_after(key, dly);
        wait_drain();
    endtask

    // Rounds 1..NR-1 take mixcol output; round NR takes shiftrows output.
    task automatic issue_round(input int r, input logic [127:0] mix, input logic [127:0] shf,
                               input logic [127:0] key, input int dly);
        logic [127:0] s;
        s = (r == NR) ? shf : mix;
        exp_q.push_back('{s ^ key, 4'(r), (r == NR)});
        if (r == NR) exp_done++;
        tick();
        bus.addkey_enable = 1'b1;
        bus.mix_data      = mix;
        bus.shift_data    = shf;
        bus.round_key     = key;
        bus.key_valid     = (dly == 0);
        tick();
        bus.addkey_enable = 1'b0;
        bus.key_valid     = 1'b0;
        key_after(key, dly);
        wait_drain();
    endtask

    task automatic rand_rounds(input int first, input int last);
        for (int r = first; r <= last; r++)
            issue_round(r, rnd128(), rnd128(), rnd128(), int'($urandom_range(0, 3)));
    endtask

    initial begin
        logic [127:0] pt, key, hold;
        int fin0, done0, kr, early;

        n_rst = 1'b0;
        bus.start = 1'b0; bus.plain_text = '0; bus.addkey_enable = 1'b0;
        bus.mix_data = '0; bus.shift_data = '0; bus.round_key = '0; bus.key_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_state_out", bus.state_out, 128'd0);
        chk("rst_round_num", 128'(bus.round_num), 128'd0);
        chk("rst_key_req", 128'(bus.key_req), 128'd0);
        chk("rst_finished", 128'(bus.addkey_finished), 128'd0);
        chk("rst_cipher_done", 128'(bus.cipher_done), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        #10 n_rst = 1'b1;

        // Spurious addkey_enable / key_valid while IDLE
        tick();
        bus.addkey_enable = 1'b1; bus.key_valid = 1'b1; bus.mix_data = rnd128(); bus.round_key = rnd128();
        tick();
        bus.addkey_enable = 1'b0; bus.key_valid = 1'b0;
        repeat (2) tick();
        chk("idle_spur_state_out", bus.state_out, 128'd0);
        chk("idle_spur_busy", 128'(bus.busy), 128'd0);
        chk("idle_spur_round", 128'(bus.round_num), 128'd0);
        chk("idle_spur_fin", 128'(fin_cnt), 128'd0);

        // FIPS-197 round 0 with key_valid held high
        pt  = 128'h3243f6a8885a308d313198a2e0370734;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_q.push_back('{128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0});
        tick();
        bus.start = 1'b1; bus.plain_text = pt; bus.round_key = key; bus.key_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("r0_latency_finished", 128'(bus.addkey_finished), 128'd1);
        chk("r0_state_out", bus.state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        tick();
        chk("r0_round_num_next", 128'(bus.round_num), 128'd1);
        bus.key_valid = 1'b0;
        wait_drain();

        // Key stall in round 1: key arrives 5 cycles late
        exp_q.push_back('{{16{8'hA5}}, 4'd1, 1'b0});
        kr = 0; early = 0;
        tick();
        bus.addkey_enable = 1'b1; bus.mix_data = '0; bus.shift_data = rnd128();
        bus.round_key = {16{8'hA5}}; bus.key_valid = 1'b0;
        tick();
        bus.addkey_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.key_req) kr++;
            if (bus.addkey_finished) early++;
        end
        tick();
        bus.key_valid = 1'b1;
        @(negedge clk);
        if (bus.key_req) kr++;
        if (bus.addkey_finished) early++;
        tick();
        bus.key_valid = 1'b0;
        @(negedge clk);
        chk("stall_key_req_cycles", 128'(kr), 128'd5);
        chk("stall_no_early_finish", 128'(early), 128'd0);
        chk("stall_key_req_drop", 128'(bus.key_req), 128'd0);
        chk("stall_state_out", bus.state_out, {16{8'hA5}});
        wait_drain();
        rand_rounds(2, NR);

        // Directed full block: shift_data must be selected in the last round
        fin0 = fin_cnt; done0 = done_cnt;
        issue_start(rnd128(), rnd128(), 0);
        for (int r = 1; r < NR; r++) issue_round(r, {16{8'h11}}, rnd128(), rnd128(), 0);
        issue_round(NR, '0, {16{8'hFF}}, {16{8'h0F}}, 0);
        tick();
        chk("full_state_out", bus.state_out, {16{8'hF0}});
        chk("full_fin_pulses", 128'(fin_cnt - fin0), 128'd11);
        chk("full_done_pulses", 128'(done_cnt - done0), 128'd1);
        chk("full_busy_after", 128'(bus.busy), 128'd0);
        chk("full_round_after", 128'(bus.round_num), 128'd0);

        // Abort at round 4 with a new block
        issue_start(rnd128(), rnd128(), int'($urandom_range(0, 3)));
        rand_rounds(1, 3);
        #1;
        chk("abort_pre_round", 128'(bus.round_num), 128'd4);
        done0 = done_cnt;
        issue_start({16{8'h01}}, {16{8'h01}}, 0);
        chk("abort_state_out", bus.state_out, 128'd0);
        chk("abort_no_done", 128'(done_cnt - done0), 128'd0);
        rand_rounds(1, NR);

        // Spurious addkey_enable in WAIT_KEY, then key_valid in WAIT_DATA
        pt = rnd128(); key = rnd128();
        exp_q.push_back('{pt ^ key, 4'd0, 1'b0});
        tick();
        bus.start = 1'b1; bus.plain_text = pt; bus.key_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.addkey_enable = 1'b1; bus.mix_data = rnd128(); bus.shift_data = rnd128();
        tick();
        bus.addkey_enable = 1'b0;
        bus.round_key = key; bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        wait_drain();
        hold = pt ^ key;
        tick();
        bus.key_valid = 1'b1; bus.round_key = rnd128();
        tick();
        bus.key_valid = 1'b0;
        repeat (2) tick();
        chk("wd_spur_state_out", bus.state_out, hold);
        chk("wd_spur_round", 128'(bus.round_num), 128'd1);
        chk("wd_spur_busy", 128'(bus.busy), 128'd1);
        chk("wd_spur_key_req", 128'(bus.key_req), 128'd0);

        // Asynchronous reset while waiting for a key
        bus.addkey_enable = 1'b1; bus.mix_data = rnd128();
        tick();
        bus.addkey_enable = 1'b0;
        @(negedge clk);
        chk("pre_reset_key_req", 128'(bus.key_req), 128'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_state_out", bus.state_out, 128'd0);
        chk("arst_round_num", 128'(bus.round_num), 128'd0);
        chk("arst_key_req", 128'(bus.key_req), 128'd0);
        chk("arst_busy", 128'(bus.busy), 128'd0);
        chk("arst_finished", 128'(bus.addkey_finished), 128'd0);
        chk("arst_cipher_done", 128'(bus.cipher_done), 128'd0);
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        fin0 = fin_cnt;
        tick();
        bus.key_valid = 1'b1; bus.addkey_enable = 1'b1; bus.round_key = rnd128();
        tick();
        bus.key_valid = 1'b0; bus.addkey_enable = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", 128'(bus.busy), 128'd0);
        chk("post_rst_round", 128'(bus.round_num), 128'd0);
        chk("post_rst_fin", 128'(fin_cnt - fin0), 128'd0);

        // Randomized full blocks
        for (int b = 0; b < 3; b++) begin
            issue_start(rnd128(), rnd128(), int'($urandom_range(0, 3)));
            rand_rounds(1, NR);
        end
        repeat (3) tick();
        chk("cipher_done_total", 128'(done_cnt), 128'(exp_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
